// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   VGA raster generator. A divider turns clk_100 into a pixel tick. On every tick the
//   horizontal/vertical position advances, and the sync, display-enable and coordinate
//   outputs are decoded from the position being loaded. A prefetch port requests the
//   frame-buffer pixel for the position one tick ahead.
//
// Ports
//   clk_100      in   system clock, the only clock
//   rst          in   synchronous reset, active-high
//   en           in   run enable; low behaves like rst
//   pix_tick     out  one-cycle pulse per pixel period
//   hsync/vsync  out  sync outputs, asserted level SYNC_POL
//   de           out  display enable (visible area)
//   x, y         out  pixel coordinates while de, else 0
//   line_start   out  pulse when h wraps to 0
//   frame_start  out  pulse when (h,v) wraps to (0,0)
//   rd_req       out  pulse: fetch pixel for the next position
//   rd_addr      out  linear address of the prefetched pixel
//
// Table of states
//   (no FSM; the state is the div_cnt/h/v/addr counter set)
module vga_timing_ctrl #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        en,
    output logic        pix_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic        rd_req,
    output logic [18:0] rd_addr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_RST     = 10'(H_TOTAL - 2);
    localparam logic [9:0]    H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0]    V_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_BEG    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_BEG    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0]   ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic          SYNC_ON   = (SYNC_POL != 0);
    localparam logic          SYNC_OFF  = ~SYNC_ON;

    logic [DW-1:0] div_cnt;
    logic [9:0]    h, v;
    logic [18:0]   addr;

    logic          tick;
    logic [9:0]    h_nxt, v_nxt;   // position loaded on this tick
    logic [9:0]    h_nn, v_nn;     // position loaded on the tick after
    logic          de_nxt;
    logic          fetch;

    always_comb begin
        tick  = (div_cnt == DIV_LAST);

        h_nxt = (h == H_LAST) ? 10'd0 : h + 10'd1;
        v_nxt = v;
        if (h == H_LAST)
            v_nxt = (v == V_LAST) ? 10'd0 : v + 10'd1;

        h_nn = (h_nxt == H_LAST) ? 10'd0 : h_nxt + 10'd1;
        v_nn = v_nxt;
        if (h_nxt == H_LAST)
            v_nn = (v_nxt == V_LAST) ? 10'd0 : v_nxt + 10'd1;

        de_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        // Request the pixel that becomes visible one tick from now.
        fetch  = (h_nn < H_VIS) && (v_nn < V_VIS);
    end

    always_ff @(posedge clk_100) begin
        if (rst || !en) begin
            // h sits two before the wrap so the first tick prefetches (0,0)
            // and the second tick displays it with frame_start.
            div_cnt     <= '0;
            h           <= H_RST;
            v           <= V_LAST;
            addr        <= '0;
            pix_tick    <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
        end else begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            rd_req      <= 1'b0;
            if (tick) begin
                div_cnt     <= '0;
                h           <= h_nxt;
                v           <= v_nxt;
                pix_tick    <= 1'b1;
                hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? SYNC_ON : SYNC_OFF;
                vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? SYNC_ON : SYNC_OFF;
                de          <= de_nxt;
                x           <= de_nxt ? h_nxt : 10'd0;
                y           <= de_nxt ? v_nxt : 10'd0;
                line_start  <= (h_nxt == 10'd0);
                frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
                if (fetch) begin
                    // Requests arrive in raster order, so a running counter
                    // tracks y*H_ACTIVE+x without a multiplier.
                    rd_req  <= 1'b1;
                    rd_addr <= addr;
                    addr    <= (addr == ADDR_LAST) ? 19'd0 : addr + 19'd1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

    logic clk_100 = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk_100 = ~clk_100;

    // Default-parameter instance
    logic        d_pix_tick, d_hsync, d_vsync, d_de, d_line_start, d_frame_start, d_rd_req;
    logic [9:0]  d_x, d_y;
    logic [18:0] d_rd_addr;

    // Small instance: 15 x 8 raster, 8 x 4 visible, DIV=2, active-high sync
    logic        s_pix_tick, s_hsync, s_vsync, s_de, s_line_start, s_frame_start, s_rd_req;
    logic [9:0]  s_x, s_y;
    logic [18:0] s_rd_addr;

    vga_timing_ctrl dut_d (
        .clk_100(clk_100), .rst(rst), .en(en),
        .pix_tick(d_pix_tick), .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
        .x(d_x), .y(d_y), .line_start(d_line_start), .frame_start(d_frame_start),
        .rd_req(d_rd_req), .rd_addr(d_rd_addr)
    );

    vga_timing_ctrl #(
        .DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
    ) dut_s (
        .clk_100(clk_100), .rst(rst), .en(en),
        .pix_tick(s_pix_tick), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
        .x(s_x), .y(s_y), .line_start(s_line_start), .frame_start(s_frame_start),
        .rd_req(s_rd_req), .rd_addr(s_rd_addr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int at_edge;
        bit sel;        // 1 = default instance, 0 = small instance
        bit pix, hs, vs, de;
        int x, y;
        bit ls, fs, rq;
        int addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int e, bit sel, bit pix, bit hs, bit vs, bit de_v,
                                int xv, int yv, bit ls, bit fs, bit rq, int addr);
        vec_t r;
        r.at_edge = e; r.sel = sel; r.pix = pix; r.hs = hs; r.vs = vs; r.de = de_v;
        r.x = xv; r.y = yv; r.ls = ls; r.fs = fs; r.rq = rq; r.addr = addr;
        return r;
    endfunction

    task automatic check_row(input vec_t r);
        string t;
        t = $sformatf("%s@e%0d", r.sel ? "def" : "small", r.at_edge);
        if (r.sel) begin
            chk({t, " pix_tick"}, d_pix_tick, r.pix);
            chk({t, " hsync"}, d_hsync, r.hs);
            chk({t, " vsync"}, d_vsync, r.vs);
            chk({t, " de"}, d_de, r.de);
            chk({t, " x"}, d_x, r.x);
            chk({t, " y"}, d_y, r.y);
            chk({t, " line_start"}, d_line_start, r.ls);
            chk({t, " frame_start"}, d_frame_start, r.fs);
            chk({t, " rd_req"}, d_rd_req, r.rq);
            chk({t, " rd_addr"}, d_rd_addr, r.addr);
        end else begin
            chk({t, " pix_tick"}, s_pix_tick, r.pix);
            chk({t, " hsync"}, s_hsync, r.hs);
            chk({t, " vsync"}, s_vsync, r.vs);
            chk({t, " de"}, s_de, r.de);
            chk({t, " x"}, s_x, r.x);
            chk({t, " y"}, s_y, r.y);
            chk({t, " line_start"}, s_line_start, r.ls);
            chk({t, " frame_start"}, s_frame_start, r.fs);
            chk({t, " rd_req"}, s_rd_req, r.rq);
            chk({t, " rd_addr"}, s_rd_addr, r.addr);
        end
    endtask

    task automatic check_small_idle(input string tag);
        chk({tag, " pix_tick"}, s_pix_tick, 0);
        chk({tag, " hsync"}, s_hsync, 0);
        chk({tag, " vsync"}, s_vsync, 0);
        chk({tag, " de"}, s_de, 0);
        chk({tag, " x"}, s_x, 0);
        chk({tag, " y"}, s_y, 0);
        chk({tag, " line_start"}, s_line_start, 0);
        chk({tag, " frame_start"}, s_frame_start, 0);
        chk({tag, " rd_req"}, s_rd_req, 0);
        chk({tag, " rd_addr"}, s_rd_addr, 0);
    endtask

    // Called #1 after the edge on which rst/en are already released.
    task automatic restart_check(input string tag);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk_100); #1;
            if (e == 1) chk({tag, " e1 pix_tick"}, s_pix_tick, 0);
            if (e == 2) begin
                chk({tag, " e2 pix_tick"}, s_pix_tick, 1);
                chk({tag, " e2 rd_req"}, s_rd_req, 1);
                chk({tag, " e2 rd_addr"}, s_rd_addr, 0);
                chk({tag, " e2 de"}, s_de, 0);
                chk({tag, " e2 frame_start"}, s_frame_start, 0);
            end
            if (e == 4) begin
                chk({tag, " e4 frame_start"}, s_frame_start, 1);
                chk({tag, " e4 line_start"}, s_line_start, 1);
                chk({tag, " e4 de"}, s_de, 1);
                chk({tag, " e4 x"}, s_x, 0);
                chk({tag, " e4 y"}, s_y, 0);
                chk({tag, " e4 rd_addr"}, s_rd_addr, 1);
            end
        end
    endtask

    // Prefetch scoreboard on the small instance: addresses advance by one and
    // wrap after 31, and each request matches y*8+x of the next tick's pixel.
    int  exp_addr = 0;
    bit  pend = 0;
    int  pend_addr = 0;

    initial begin
        forever begin
            @(negedge clk_100);
            if (rst || !en) begin
                exp_addr = 0;
                pend = 0;
            end else if (s_pix_tick) begin
                if (pend) begin
                    chk("prefetch de", s_de, 1);
                    chk("prefetch addr vs y*8+x", s_y * 8 + s_x, pend_addr);
                    pend = 0;
                end
                if (s_rd_req) begin
                    chk("rd_addr sequence", s_rd_addr, exp_addr);
                    exp_addr = (exp_addr == 31) ? 0 : exp_addr + 1;
                    pend = 1;
                    pend_addr = s_rd_addr;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc, tix, hs_cnt, first_hs, de_cnt, vs_cnt, first_vs, last_de, rq_cnt;
        bit found;

        //            edge sel pix hs vs de  x  y ls fs rq addr
        vecs.push_back(mk(1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2,   0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3,   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4,   0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(4,   1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(5,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(5,   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8,   1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(9,   1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(18,  0, 1, 0, 0, 1, 7, 0, 0, 0, 0, 7));
        vecs.push_back(mk(20,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        vecs.push_back(mk(24,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7));
        vecs.push_back(mk(28,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7));
        vecs.push_back(mk(30,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        vecs.push_back(mk(32,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 8));
        vecs.push_back(mk(34,  0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 9));
        vecs.push_back(mk(108, 0, 1, 0, 0, 1, 7, 3, 0, 0, 0, 31));
        vecs.push_back(mk(154, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 31));
        vecs.push_back(mk(212, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 31));
        vecs.push_back(mk(214, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 31));
        vecs.push_back(mk(242, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(244, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1));

        // Reset held for three edges: both instances idle.
        rst = 1'b1; en = 1'b1;
        repeat (3) @(posedge clk_100);
        #1;
        check_small_idle("reset small");
        chk("reset def hsync", d_hsync, 1);
        chk("reset def vsync", d_vsync, 1);
        chk("reset def pix_tick", d_pix_tick, 0);
        chk("reset def rd_req", d_rd_req, 0);
        rst = 1'b0;

        // Table: edge numbers counted from release.
        n = 0;
        foreach (vecs[i]) begin
            while (n < vecs[i].at_edge) begin
                @(posedge clk_100); #1;
                n++;
            end
            check_row(vecs[i]);
        end

        // One full line on the default instance.
        found = 0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(posedge clk_100); #1;
            if (d_line_start) found = 1;
        end
        chk("def line_start seen", found, 1);
        cyc = 0; tix = 0; hs_cnt = 0; first_hs = -1; de_cnt = d_de ? 1 : 0;
        found = 0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(posedge clk_100); #1;
            cyc++;
            if (d_line_start) found = 1;
            else if (d_pix_tick) begin
                tix++;
                if (!d_hsync) begin
                    hs_cnt++;
                    if (first_hs < 0) first_hs = tix;
                end
                if (d_de) de_cnt++;
            end
        end
        chk("def next line_start seen", found, 1);
        chk("def line period clk", cyc, 3200);
        chk("def hsync low ticks", hs_cnt, 96);
        chk("def hsync first h", first_hs, 656);
        chk("def de ticks per line", de_cnt, 640);

        // One full frame on the small instance.
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk_100); #1;
            if (s_frame_start) found = 1;
        end
        chk("small frame_start seen", found, 1);
        cyc = 0; tix = 0; vs_cnt = 0; first_vs = -1; last_de = 0;
        de_cnt = s_de ? 1 : 0;
        rq_cnt = s_rd_req ? 1 : 0;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk_100); #1;
            cyc++;
            if (s_frame_start) found = 1;
            else if (s_pix_tick) begin
                tix++;
                if (s_vsync) begin
                    vs_cnt++;
                    if (first_vs < 0) first_vs = tix;
                end
                if (s_de) begin
                    de_cnt++;
                    last_de = tix;
                end
                if (s_rd_req) rq_cnt++;
            end
        end
        chk("small next frame_start seen", found, 1);
        chk("small frame period clk", cyc, 240);
        chk("small vsync ticks", vs_cnt, 30);
        chk("small vsync first tick", first_vs, 75);
        chk("small de ticks", de_cnt, 32);
        chk("small last de tick", last_de, 52);
        chk("small rd_req per frame", rq_cnt, 32);

        // en dropped for one edge mid-frame, then a clean restart.
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk_100); #1;
            if (s_pix_tick && s_de && s_x == 10'd3 && s_y == 10'd2) found = 1;
        end
        chk("small reached (3,2)", found, 1);
        en = 1'b0;
        @(posedge clk_100); #1;
        check_small_idle("en drop");
        chk("en drop def hsync", d_hsync, 1);
        chk("en drop def de", d_de, 0);
        en = 1'b1;
        restart_check("re-enable");

        // rst lands on a tick edge: reset wins.
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk_100); #1;
            if (s_pix_tick) found = 1;
        end
        chk("small tick before rst", found, 1);
        @(posedge clk_100); #1;
        rst = 1'b1;
        @(posedge clk_100); #1;
        check_small_idle("rst on tick");
        rst = 1'b0;
        restart_check("after rst on tick");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
